// File: rtl/cmd_frame_tx_pkg.sv
// Shared types and constants for the command frame serializer.
// Field positions describe the layout of the keypad command byte.
package cmd_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_GAP
    } tx_state_e;

    localparam int         FRAME_BITS  = 11;
    localparam int         DATA_BITS   = FRAME_BITS - 3;
    localparam logic       START_BIT   = 1'b0;
    localparam logic       STOP_BIT    = 1'b1;
    localparam logic [1:0] CHECK_FIELD = 2'b10;

    localparam int SPEED_LSB = 0;
    localparam int SPEED_MSB = 1;
    localparam int STEER_LSB = 2;
    localparam int STEER_MSB = 3;
    localparam int DIR_BIT   = 4;
    localparam int MODE_BIT  = 5;
    localparam int CHECK_LSB = 6;
    localparam int CHECK_MSB = 7;

    function automatic logic check_ok(input logic [7:0] cmd);
        return cmd[CHECK_MSB:CHECK_LSB] == CHECK_FIELD;
    endfunction

endpackage

// File: rtl/cmd_frame_tx_if.sv
// Command/strobe handshake from the keypad-command stage into the serializer.
interface cmd_frame_tx_if;
    logic [7:0] command;
    logic       send;

    modport master (output command, output send);
    modport slave  (input  command, input  send);
endinterface

// File: rtl/cmd_bit_timer.sv
// Bit-period timer: counts 0..BIT_TICKS-1 and flags the last tick of each bit.
module cmd_bit_timer #(
    parameter int BIT_TICKS = 10
) (
    input  logic clk_10k,
    input  logic rst,
    input  logic restart,
    output logic bit_done
);

    localparam int CNT_W = $clog2(BIT_TICKS);

    logic [CNT_W-1:0] count;

    assign bit_done = (count == CNT_W'(BIT_TICKS - 1));

    always_ff @(posedge clk_10k) begin
        if (rst || restart) begin
            count <= '0;
        end else if (bit_done) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cmd_frame_tx.sv
// Serializes accepted command bytes into repeated 11-bit idle-high frames,
// with a one-deep pending buffer for commands arriving mid-transmission.
module cmd_frame_tx
    import cmd_frame_tx_pkg::*;
#(
    parameter int BIT_TICKS = 10,
    parameter int REPEAT    = 3,
    parameter int GAP_BITS  = 4
) (
    input  logic                 clk_10k,
    input  logic                 rst,
    cmd_frame_tx_if.slave        cmd_in,
    output logic                 tx,
    output logic                 busy,
    output logic                 rejected,
    output logic                 overrun
);

    localparam int IDX_W = (GAP_BITS > 8) ? $clog2(GAP_BITS) : 3;
    localparam int REP_W = $clog2(REPEAT + 1);

    tx_state_e        state;
    logic [7:0]       data_q;
    logic [7:0]       pend_data;
    logic             pend_valid;
    logic [IDX_W-1:0] idx;
    logic [REP_W-1:0] rep_cnt;

    logic bit_done;
    logic cmd_ok;
    logic accept;
    logic frame_end;
    logic rep_more;
    logic take_pend;
    logic take_new;

    cmd_bit_timer #(.BIT_TICKS(BIT_TICKS)) u_timer (
        .clk_10k  (clk_10k),
        .rst      (rst),
        .restart  (state == ST_IDLE),
        .bit_done (bit_done)
    );

    assign cmd_ok   = check_ok(cmd_in.command);
    assign accept   = cmd_in.send && cmd_ok;
    assign rep_more = rep_cnt < REP_W'(REPEAT);

    // The last tick of the gap (or of the stop bit when there is no gap) is
    // where the next frame is chosen, so a fresh send there skips IDLE.
    always_comb begin
        frame_end = 1'b0;
        if (bit_done) begin
            if (state == ST_STOP && GAP_BITS == 0) frame_end = 1'b1;
            if (state == ST_GAP && int'(idx) == GAP_BITS - 1) frame_end = 1'b1;
        end
    end

    assign take_pend = frame_end && !rep_more && pend_valid;
    assign take_new  = frame_end && !rep_more && !pend_valid && accept;

    always_ff @(posedge clk_10k) begin
        if (rst) begin
            state      <= ST_IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            rejected   <= 1'b0;
            overrun    <= 1'b0;
            data_q     <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            idx        <= '0;
            rep_cnt    <= '0;
        end else begin
            rejected <= cmd_in.send && !cmd_ok;
            overrun  <= 1'b0;

            // Pending write wins over consumption, so a send coinciding with
            // a pending load leaves the flag set without flagging overrun.
            if (state != ST_IDLE && accept && !take_new) begin
                pend_data  <= cmd_in.command;
                pend_valid <= 1'b1;
                overrun    <= pend_valid && !take_pend;
            end else if (take_pend) begin
                pend_valid <= 1'b0;
            end

            if (frame_end) begin
                idx <= '0;
                if (rep_more) begin
                    rep_cnt <= rep_cnt + REP_W'(1);
                    state   <= ST_START;
                    tx      <= START_BIT;
                end else if (pend_valid) begin
                    data_q  <= pend_data;
                    rep_cnt <= REP_W'(1);
                    state   <= ST_START;
                    tx      <= START_BIT;
                end else if (accept) begin
                    data_q  <= cmd_in.command;
                    rep_cnt <= REP_W'(1);
                    state   <= ST_START;
                    tx      <= START_BIT;
                end else begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        tx <= 1'b1;
                        if (accept) begin
                            data_q  <= cmd_in.command;
                            rep_cnt <= REP_W'(1);
                            idx     <= '0;
                            state   <= ST_START;
                            tx      <= START_BIT;
                            busy    <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if (bit_done) begin
                            state <= ST_DATA;
                            idx   <= '0;
                            tx    <= data_q[0];
                        end
                    end
                    ST_DATA: begin
                        if (bit_done) begin
                            if (idx == IDX_W'(DATA_BITS - 1)) begin
                                state <= ST_PARITY;
                                tx    <= ^data_q;
                            end else begin
                                idx <= idx + IDX_W'(1);
                                tx  <= data_q[idx[2:0] + 3'd1];
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (bit_done) begin
                            state <= ST_STOP;
                            tx    <= STOP_BIT;
                        end
                    end
                    ST_STOP: begin
                        if (bit_done) begin
                            state <= ST_GAP;
                            idx   <= '0;
                            tx    <= 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (bit_done) idx <= idx + IDX_W'(1);
                    end
                    default: begin
                        state <= ST_IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
